// File: rtl/fuse_queue.sv
// Decode-to-rename fusion queue: fuses LUI/AUIPC+ADDI and ADDI+branch pairs, buffers the survivors.
// Optional macro FUSE_STATS_EN adds the saturating OUT_fuseCnt fusion counter.
// Uop lane layout, MSB first (95 bits): valid, imm[31:0], rs0[4:0], rs1[4:0], imm_b, rd[4:0],
// opcode[5:0], fu[2:0], pc[31:0], branch_id[2:0], branch_pred, compressed. Slot 0 is the low lane.
module fuse_queue #(
  parameter int unsigned NUM_UOPS_IN  = 4,
  parameter int unsigned NUM_UOPS_OUT = 3,
  parameter int unsigned BUF_SIZE     = 16,
  parameter int unsigned FULL_THRESH  = 5,
  localparam int unsigned UopW        = 95,
  localparam int unsigned FreeW       = $clog2(BUF_SIZE) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          IN_flush,
  input  logic                          IN_outEn,
  input  logic [1:0]                    IN_fuseEn,
  input  logic [NUM_UOPS_IN*UopW-1:0]   IN_uop,
  output logic                          OUT_full,
  output logic [FreeW-1:0]              OUT_free,
  output logic [NUM_UOPS_OUT*UopW-1:0]  OUT_uop
`ifdef FUSE_STATS_EN
  ,
  output logic [31:0]                   OUT_fuseCnt
`endif
);

  localparam int unsigned PtrW    = $clog2(BUF_SIZE);
  localparam int unsigned FuseW   = $clog2(NUM_UOPS_IN) + 1;
  localparam logic [2:0]  FuInt   = 3'd0;
  localparam logic [5:0]  OpAdd   = 6'd0;
  localparam logic [5:0]  OpLui   = 6'd1;
  localparam logic [5:0]  OpAuipc = 6'd2;
  localparam logic [5:0]  OpBeq   = 6'd3;
  localparam logic [5:0]  OpBgeu  = 6'd8;
  // INT_F_ADDI_Bxx opcodes follow the six branch opcodes in the same order.
  localparam logic [5:0]  FusedOfs = 6'd6;

  typedef struct packed {
    logic        valid;
    logic [31:0] imm;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic        imm_b;
    logic [4:0]  rd;
    logic [5:0]  opcode;
    logic [2:0]  fu;
    logic [31:0] pc;
    logic [2:0]  branch_id;
    logic        branch_pred;
    logic        compressed;
  } uop_t;

  function automatic logic is_lui_addi(uop_t a, uop_t b);
    return a.valid && b.valid && a.fu == FuInt && b.fu == FuInt &&
           (a.opcode == OpLui || a.opcode == OpAuipc) &&
           b.opcode == OpAdd && b.imm_b && b.rs0 == b.rd && b.rd == a.rd;
  endfunction

  function automatic uop_t fuse_lui_addi(uop_t a, uop_t b);
    uop_t r;
    r        = a;
    r.opcode = OpAdd;
    r.imm_b  = 1'b1;
    r.imm    = {a.imm[31:12], 12'b0} + {{20{b.imm[11]}}, b.imm[11:0]};
    return r;
  endfunction

  function automatic logic is_addi_br(uop_t a, uop_t b);
    return a.valid && b.valid && a.fu == FuInt && b.fu == FuInt &&
           a.opcode == OpAdd && a.imm_b && a.rs0 == a.rd &&
           b.opcode >= OpBeq && b.opcode <= OpBgeu && b.rs0 == a.rd;
  endfunction

  function automatic uop_t fuse_addi_br(uop_t a, uop_t b);
    uop_t r;
    r        = b;
    r.rd     = a.rd;
    r.imm_b  = 1'b0;
    r.opcode = b.opcode + FusedOfs;
    r.imm    = {a.imm[11:0], 7'b0, b.imm[12:0]};
    return r;
  endfunction

  uop_t              in_u     [NUM_UOPS_IN];
  uop_t              win_q    [NUM_UOPS_IN];
  uop_t              win_d    [NUM_UOPS_IN];
  uop_t              ins_q    [NUM_UOPS_IN];
  uop_t              ins_d    [NUM_UOPS_IN];
  uop_t              out_q    [NUM_UOPS_OUT];
  uop_t              out_d    [NUM_UOPS_OUT];
  uop_t              mem_q    [BUF_SIZE];
  uop_t              win_ext  [NUM_UOPS_IN+1];
  uop_t              fused    [NUM_UOPS_IN+1];
  logic              fuse_skip;
  logic              cross_fuse;
  logic [FuseW-1:0]  n_fuse;

  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   wr_idx   [NUM_UOPS_IN];
  logic [FreeW-1:0]  free_q, free_d;
  logic [FreeW-1:0]  used;
  logic [FreeW-1:0]  wr_cnt;
  logic [FreeW-1:0]  rd_cnt;
  logic              full_q, full_d;
  logic              adv;
  logic              wr_en;

  always_comb begin
    for (int i = 0; i < NUM_UOPS_IN; i++) begin
      in_u[i] = uop_t'(IN_uop[i*UopW +: UopW]);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_UOPS_IN; i++) begin
      win_ext[i] = win_q[i];
    end
    win_ext[NUM_UOPS_IN] = in_u[0];
  end

  // Low-to-high pair scan; a fused pair consumes both members so the next pair start is skipped.
  always_comb begin
    fused     = win_ext;
    fuse_skip = 1'b0;
    n_fuse    = '0;
    for (int i = 0; i < NUM_UOPS_IN; i++) begin
      if (fuse_skip) begin
        fuse_skip = 1'b0;
      end else if (IN_fuseEn[0] && is_lui_addi(win_ext[i], win_ext[i+1])) begin
        fused[i]         = fuse_lui_addi(win_ext[i], win_ext[i+1]);
        fused[i+1].valid = 1'b0;
        fuse_skip        = 1'b1;
        n_fuse           = n_fuse + FuseW'(1);
      end else if (IN_fuseEn[1] && is_addi_br(win_ext[i], win_ext[i+1])) begin
        fused[i]         = fuse_addi_br(win_ext[i], win_ext[i+1]);
        fused[i+1].valid = 1'b0;
        fuse_skip        = 1'b1;
        n_fuse           = n_fuse + FuseW'(1);
      end
    end
    cross_fuse = in_u[0].valid && !fused[NUM_UOPS_IN].valid;
  end

  assign adv   = !full_q;
  assign wr_en = adv && !IN_flush;

  always_comb begin
    win_d = win_q;
    ins_d = ins_q;
    if (adv) begin
      for (int i = 0; i < NUM_UOPS_IN; i++) begin
        win_d[i] = in_u[i];
        ins_d[i] = fused[i];
      end
      // The upper half of a cross-group pair already lives in the fused slot N-1.
      win_d[0].valid = in_u[0].valid && !cross_fuse;
    end
    if (IN_flush) begin
      for (int i = 0; i < NUM_UOPS_IN; i++) begin
        win_d[i].valid = 1'b0;
        ins_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    wr_cnt = '0;
    for (int i = 0; i < NUM_UOPS_IN; i++) begin
      wr_idx[i] = wr_ptr_q + PtrW'(wr_cnt);
      if (ins_q[i].valid) wr_cnt = wr_cnt + FreeW'(1);
    end
  end

  always_comb begin
    used   = FreeW'(BUF_SIZE) - free_q;
    rd_cnt = '0;
    for (int i = 0; i < NUM_UOPS_OUT; i++) begin
      out_d[i] = '0;
      if (IN_outEn && FreeW'(i) < used) begin
        out_d[i]       = mem_q[rd_ptr_q + PtrW'(i)];
        out_d[i].valid = 1'b1;
        rd_cnt         = rd_cnt + FreeW'(1);
      end
    end
    rd_ptr_d = rd_ptr_q + PtrW'(rd_cnt);
    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(wr_cnt) : wr_ptr_q;
    free_d   = free_q + rd_cnt - (wr_en ? wr_cnt : '0);
    full_d   = free_d < FreeW'(FULL_THRESH);
    if (IN_flush) begin
      for (int i = 0; i < NUM_UOPS_OUT; i++) begin
        out_d[i].valid = 1'b0;
      end
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      free_d   = FreeW'(BUF_SIZE);
      full_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_UOPS_IN; i++) begin
        win_q[i] <= '0;
        ins_q[i] <= '0;
      end
      for (int i = 0; i < NUM_UOPS_OUT; i++) begin
        out_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      free_q   <= FreeW'(BUF_SIZE);
      full_q   <= 1'b0;
    end else begin
      win_q    <= win_d;
      ins_q    <= ins_d;
      out_q    <= out_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      free_q   <= free_d;
      full_q   <= full_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers and free count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_UOPS_IN; i++) begin
        if (ins_q[i].valid) mem_q[wr_idx[i]] <= ins_q[i];
      end
    end
  end

  always_comb begin
    OUT_uop = '0;
    for (int i = 0; i < NUM_UOPS_OUT; i++) begin
      OUT_uop[i*UopW +: UopW] = out_q[i];
    end
  end

  assign OUT_free = free_q;
  assign OUT_full = full_q;

  no_overflow_a : assert property (@(posedge clk) disable iff (!rst) wr_en |-> wr_cnt <= free_q)
    else $error("fuse_queue: buffer overflow");

`ifdef FUSE_STATS_EN
  logic [31:0] fuse_cnt_q, fuse_cnt_d;
  logic [32:0] fuse_sum;

  always_comb begin
    fuse_sum   = {1'b0, fuse_cnt_q} + 33'(n_fuse);
    fuse_cnt_d = fuse_cnt_q;
    if (wr_en) fuse_cnt_d = fuse_sum[32] ? '1 : fuse_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fuse_cnt_q <= '0;
    else      fuse_cnt_q <= fuse_cnt_d;
  end

  assign OUT_fuseCnt = fuse_cnt_q;
`endif

endmodule
